// File: rtl/ap_table_ctrl.sv
// Write sequencer for the ap_lookup action table: arbitrates software writes against
// watchdog flushes, draining in-flight lookups before zero-filling every entry.
module ap_table_ctrl #(
    parameter int TABLE_DEPTH      = 32,
    parameter int TABLE_ADDR_WIDTH = 5,
    parameter int ENTRY_WIDTH      = 64,
    parameter int FLUSH_CNT_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        table_flush,
    input  logic                        sw_wr_req,
    input  logic [TABLE_ADDR_WIDTH-1:0] sw_wr_addr,
    input  logic [ENTRY_WIDTH-1:0]      sw_wr_data,
    output logic                        sw_wr_ack,
    output logic                        tbl_wr_en,
    output logic [TABLE_ADDR_WIDTH-1:0] tbl_wr_addr,
    output logic [ENTRY_WIDTH-1:0]      tbl_wr_data,
    input  logic                        tbl_wr_rdy,
    output logic                        lookup_hold,
    input  logic                        lookup_idle,
    output logic                        flush_busy,
    output logic [FLUSH_CNT_WIDTH-1:0]  flush_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SW_WR,
        S_DRAIN,
        S_FLUSH,
        S_DONE
    } state_t;

    localparam logic [TABLE_ADDR_WIDTH-1:0] LAST_ADDR = TABLE_ADDR_WIDTH'(TABLE_DEPTH - 1);

    state_t                      state_q, state_d;
    logic                        pending_q, pending_d;
    logic                        ack_q, ack_d;
    logic                        en_q, en_d;
    logic [TABLE_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ENTRY_WIDTH-1:0]      data_q, data_d;
    logic                        hold_q, hold_d;
    logic [FLUSH_CNT_WIDTH-1:0]  count_q, count_d;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        ack_d     = 1'b0;
        en_d      = en_q;
        addr_d    = addr_q;
        data_d    = data_q;
        hold_d    = hold_q;
        count_d   = count_q;

        case (state_q)
            S_IDLE: begin
                if (table_flush || pending_q) begin
                    state_d   = S_DRAIN;
                    pending_d = 1'b0;
                    hold_d    = 1'b1;
                    en_d      = 1'b0;
                end else if (sw_wr_req && !ack_q) begin
                    // ack_q high means this request was just committed; do not replay it
                    state_d = S_SW_WR;
                    en_d    = 1'b1;
                    addr_d  = sw_wr_addr;
                    data_d  = sw_wr_data;
                end
            end
            S_SW_WR: begin
                if (table_flush) begin
                    pending_d = 1'b1;
                end
                if (tbl_wr_rdy) begin
                    state_d = S_IDLE;
                    en_d    = 1'b0;
                    ack_d   = 1'b1;
                end
            end
            S_DRAIN: begin
                if (table_flush) begin
                    pending_d = 1'b1;
                end
                if (lookup_idle) begin
                    state_d = S_FLUSH;
                    en_d    = 1'b1;
                    addr_d  = '0;
                    data_d  = '0;
                end
            end
            S_FLUSH: begin
                if (table_flush) begin
                    pending_d = 1'b1;
                end
                if (tbl_wr_rdy) begin
                    if (addr_q == LAST_ADDR) begin
                        state_d = S_DONE;
                        en_d    = 1'b0;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                count_d = count_q + 1'b1;
                // A request arriving now merges with any queued one into a single re-flush
                if (pending_q || table_flush) begin
                    state_d   = S_DRAIN;
                    pending_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                    hold_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                en_d    = 1'b0;
                hold_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pending_q <= 1'b0;
            ack_q     <= 1'b0;
            en_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            hold_q    <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            ack_q     <= ack_d;
            en_q      <= en_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            hold_q    <= hold_d;
            count_q   <= count_d;
        end
    end

    assign sw_wr_ack   = ack_q;
    assign tbl_wr_en   = en_q;
    assign tbl_wr_addr = addr_q;
    assign tbl_wr_data = data_q;
    assign lookup_hold = hold_q;
    assign flush_busy  = hold_q;
    assign flush_count = count_q;

endmodule

// File: tb/tb_ap_table_ctrl.sv
// Self-checking bench for ap_table_ctrl: directed scenarios plus randomized traffic,
// compared every cycle against a behavioural model and a table-content scoreboard.
module tb_ap_table_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        table_flush = 1'b0;
    logic        sw_wr_req = 1'b0;
    logic [4:0]  sw_wr_addr = '0;
    logic [63:0] sw_wr_data = '0;
    logic        tbl_wr_rdy = 1'b1;
    logic        lookup_idle = 1'b1;
    logic        sw_wr_ack, tbl_wr_en, lookup_hold, flush_busy;
    logic [4:0]  tbl_wr_addr;
    logic [63:0] tbl_wr_data;
    logic [15:0] flush_count;

    ap_table_ctrl dut (
        .clk(clk), .reset(reset), .table_flush(table_flush),
        .sw_wr_req(sw_wr_req), .sw_wr_addr(sw_wr_addr), .sw_wr_data(sw_wr_data),
        .sw_wr_ack(sw_wr_ack), .tbl_wr_en(tbl_wr_en), .tbl_wr_addr(tbl_wr_addr),
        .tbl_wr_data(tbl_wr_data), .tbl_wr_rdy(tbl_wr_rdy), .lookup_hold(lookup_hold),
        .lookup_idle(lookup_idle), .flush_busy(flush_busy), .flush_count(flush_count)
    );

    initial forever #5 clk = ~clk;

    int  n_tests = 0;
    int  n_fail = 0;
    int  cyc = 0;
    bit  chk_on = 1'b0;
    bit  rdy_mode = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) tbl_wr_rdy = rdy_mode ? 1'($urandom_range(0, 1)) : 1'b1;

    // Behavioural model: outputs as they must read after each clock edge
    bit          m_en, m_ack, m_hold, m_wait, m_queued, nack;
    logic [4:0]  m_addr;
    logic [63:0] m_data;
    logic [15:0] m_count;
    logic [63:0] exp_mem [32];
    bit          exp_valid [32];

    always @(posedge clk) begin
        cyc++;
        if (m_en && tbl_wr_rdy) begin
            exp_mem[m_addr] = m_data;
            exp_valid[m_addr] = 1'b1;
        end
        if (reset) begin
            m_en = 0; m_ack = 0; m_hold = 0; m_wait = 0; m_queued = 0;
            m_addr = '0; m_data = '0; m_count = '0;
        end else begin
            nack = 1'b0;
            if (!m_hold) begin
                if (m_en) begin
                    if (table_flush) m_queued = 1'b1;
                    if (tbl_wr_rdy) begin m_en = 1'b0; nack = 1'b1; end
                end else if (table_flush || m_queued) begin
                    m_queued = 1'b0; m_hold = 1'b1; m_wait = 1'b1;
                end else if (sw_wr_req && !m_ack) begin
                    m_en = 1'b1; m_addr = sw_wr_addr; m_data = sw_wr_data;
                end
            end else if (m_wait) begin
                if (table_flush) m_queued = 1'b1;
                if (lookup_idle) begin m_wait = 1'b0; m_en = 1'b1; m_addr = '0; m_data = '0; end
            end else if (m_en) begin
                if (table_flush) m_queued = 1'b1;
                if (tbl_wr_rdy) begin
                    if (m_addr == 5'd31) m_en = 1'b0;
                    else m_addr = m_addr + 1'b1;
                end
            end else begin
                m_count = m_count + 1'b1;
                if (table_flush || m_queued) begin m_queued = 1'b0; m_wait = 1'b1; end
                else m_hold = 1'b0;
            end
            m_ack = nack;
        end
    end

    // Scoreboard of what the DUT actually put on the table bus
    logic [63:0] dut_mem [32];
    bit          dut_valid [32];
    int          wcnt [32];
    int          n_beats = 0;

    always @(posedge clk) begin
        if (tbl_wr_en === 1'b1 && tbl_wr_rdy) begin
            dut_mem[tbl_wr_addr] = tbl_wr_data;
            dut_valid[tbl_wr_addr] = 1'b1;
            wcnt[tbl_wr_addr]++;
            n_beats++;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("tbl_wr_en", tbl_wr_en, m_en);
            check("sw_wr_ack", sw_wr_ack, m_ack);
            check("lookup_hold", lookup_hold, m_hold);
            check("flush_busy", flush_busy, m_hold);
            check("flush_count", flush_count, m_count);
            if (m_en) begin
                check("tbl_wr_addr", tbl_wr_addr, m_addr);
                check("tbl_wr_data", tbl_wr_data, m_data);
            end
        end
    end

    task automatic pulse_flush();
        table_flush = 1'b1;
        @(negedge clk);
        table_flush = 1'b0;
    endtask

    task automatic wait_hold_low(input string name);
        int i;
        for (i = 0; i < 400; i++) begin
            if (!lookup_hold) break;
            @(negedge clk);
        end
        check(name, lookup_hold, 1'b0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ack"}, sw_wr_ack, 0);
        check({name, "_en"}, tbl_wr_en, 0);
        check({name, "_addr"}, tbl_wr_addr, 0);
        check({name, "_data"}, tbl_wr_data, 0);
        check({name, "_hold"}, lookup_hold, 0);
        check({name, "_busy"}, flush_busy, 0);
        check({name, "_count"}, flush_count, 0);
    endtask

    initial begin
        int k, en_at1, holdc, b0, bad, quiet, c0;
        int snap [32];
        for (int i = 0; i < 32; i++) begin exp_valid[i] = 0; dut_valid[i] = 0; wcnt[i] = 0; end

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        chk_on = 1'b1;
        @(negedge clk);

        // Software write, addr 5
        sw_wr_req = 1'b1; sw_wr_addr = 5'd5; sw_wr_data = 64'hDEAD_BEEF;
        k = 0; en_at1 = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); k++;
            if (k == 1) en_at1 = int'(tbl_wr_en);
            if (sw_wr_ack) break;
        end
        sw_wr_req = 1'b0;
        check("sw_en_latency", en_at1, 1);
        check("sw_ack_latency", k, 2);
        repeat (2) @(negedge clk);
        check("sw_mem5", dut_mem[5], 64'hDEAD_BEEF);
        check("sw_count0", flush_count, 0);

        // Plain flush: hold spans 34 cycles, 32 beats
        b0 = n_beats;
        pulse_flush();
        holdc = int'(lookup_hold);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!lookup_hold) break;
            holdc++;
        end
        check("flush_hold_cycles", holdc, 34);
        check("flush_beats", n_beats - b0, 32);
        check("flush_count1", flush_count, 1);

        // Drain wait and random backpressure
        lookup_idle = 1'b0; rdy_mode = 1'b1;
        b0 = n_beats;
        pulse_flush();
        repeat (10) @(negedge clk);
        check("drain_no_beats", n_beats - b0, 0);
        check("drain_hold", lookup_hold, 1);
        for (int i = 0; i < 32; i++) snap[i] = wcnt[i];
        lookup_idle = 1'b1;
        @(negedge clk);
        wait_hold_low("drain_flush_end");
        bad = 0;
        for (int i = 0; i < 32; i++) if (wcnt[i] - snap[i] != 1) bad++;
        check("drain_each_addr_once", bad, 0);
        check("flush_count2", flush_count, 2);
        rdy_mode = 1'b0;

        // Simultaneous flush and software write
        table_flush = 1'b1; sw_wr_req = 1'b1; sw_wr_addr = 5'd3; sw_wr_data = 64'h1;
        @(negedge clk);
        table_flush = 1'b0;
        k = 0;
        for (int i = 0; i < 200; i++) begin
            if (sw_wr_ack) begin k = 1; break; end
            @(negedge clk);
        end
        check("simul_ack_seen", k, 1);
        check("simul_ack_after_done", flush_count, 3);
        check("simul_ack_hold_low", lookup_hold, 0);
        sw_wr_req = 1'b0;
        repeat (2) @(negedge clk);
        check("simul_mem3", dut_mem[3], 64'h1);

        // Two pulses during one flush produce exactly one extra flush
        b0 = n_beats; c0 = int'(flush_count);
        pulse_flush();
        repeat (5) @(negedge clk);
        pulse_flush();
        repeat (10) @(negedge clk);
        pulse_flush();
        wait_hold_low("double_end");
        repeat (3) @(negedge clk);
        check("double_hold_stays_low", lookup_hold, 0);
        check("double_count", int'(flush_count) - c0, 2);
        check("double_beats", n_beats - b0, 64);

        // Reset in the middle of a flush
        pulse_flush();
        k = 0;
        for (int i = 0; i < 100; i++) begin
            if (tbl_wr_en && tbl_wr_addr == 5'd10) begin k = 1; break; end
            @(negedge clk);
        end
        check("reach_addr10", k, 1);
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("midreset");
        reset = 1'b0;
        @(negedge clk);
        pulse_flush();
        k = 0;
        for (int i = 0; i < 50; i++) begin
            if (tbl_wr_en) begin k = 1; break; end
            @(negedge clk);
        end
        check("restart_seen", k, 1);
        check("restart_addr0", tbl_wr_addr, 0);
        wait_hold_low("restart_end");

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            if (i % 200 == 0) rdy_mode = 1'($urandom_range(0, 1));
            reset = ($urandom_range(0, 699) == 0);
            table_flush = ($urandom_range(0, 49) == 0);
            lookup_idle = ($urandom_range(0, 4) != 0);
            if (sw_wr_req && sw_wr_ack) sw_wr_req = 1'b0;
            else if (!sw_wr_req && $urandom_range(0, 3) == 0) begin
                sw_wr_req = 1'b1;
                sw_wr_addr = 5'($urandom_range(0, 31));
                sw_wr_data = {32'($urandom), 32'($urandom)};
            end
            @(negedge clk);
        end
        reset = 1'b0; table_flush = 1'b0; lookup_idle = 1'b1; rdy_mode = 1'b0;
        quiet = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (sw_wr_req && sw_wr_ack) sw_wr_req = 1'b0;
            if (!sw_wr_req && !lookup_hold && !tbl_wr_en) quiet++;
            else quiet = 0;
            if (quiet >= 3) break;
        end
        check("random_drain", quiet >= 3, 1);
        bad = 0;
        for (int i = 0; i < 32; i++)
            if (exp_valid[i] && (!dut_valid[i] || dut_mem[i] !== exp_mem[i])) bad++;
        check("table_contents", bad, 0);

        chk_on = 1'b0;
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ap_table_ctrl.md
# ap_table_ctrl

Sequences all writes into the ap_lookup action table inside output_port_lookup. It arbitrates between software table writes arriving from the register decoder and the watchdog-driven `table_flush`. On a flush it stalls new lookups, waits for in-flight lookups to drain, then zero-fills every table entry. Flush has priority over software writes; software writes are never lost, only deferred.

## Interface
Parameters:
- TABLE_DEPTH, 32, number of table entries to clear on flush
- TABLE_ADDR_WIDTH, log2(TABLE_DEPTH) = 5, table address width
- ENTRY_WIDTH, 64, table entry width
- FLUSH_CNT_WIDTH, 16, width of completed-flush counter

Ports (name, direction, width, meaning). The block uses one clock; reset is synchronous and active-high.
- clk  in  1  the single clock
- reset  in  1  synchronous, active-high
- table_flush  in  1  watchdog flush request, pulse or level; sampled each cycle
- sw_wr_req  in  1  software write request; held until sw_wr_ack
- sw_wr_addr  in  TABLE_ADDR_WIDTH  software write address; stable while sw_wr_req is high
- sw_wr_data  in  ENTRY_WIDTH  software write data; stable while sw_wr_req is high
- sw_wr_ack  out  1  one-cycle pulse: software write committed
- tbl_wr_en  out  1  table write valid; held until tbl_wr_rdy
- tbl_wr_addr  out  TABLE_ADDR_WIDTH  table write address
- tbl_wr_data  out  ENTRY_WIDTH  table write data
- tbl_wr_rdy  in  1  table accepts the write when tbl_wr_en && tbl_wr_rdy
- lookup_hold  out  1  ap_lookup must not start new lookups
- lookup_idle  in  1  ap_lookup has no lookup in flight
- flush_busy  out  1  high from the flush request until the table is cleared
- flush_count  out  FLUSH_CNT_WIDTH  count of completed flushes; wraps modulo 2^FLUSH_CNT_WIDTH

## Operation
- **States:**
  - IDLE: serves software writes.
  - SW_WR: a software beat is on the table bus.
  - DRAIN: hold is asserted; waiting for lookup_idle.
  - FLUSH: zero-fill in progress.
  - DONE: one cycle; updates the counter and releases hold.
- **IDLE transitions:**
  - If table_flush or flush_pending is set → DRAIN; clear flush_pending.
  - Else if sw_wr_req and sw_wr_ack is low → SW_WR. Register the address and data; tbl_wr_en=1.
  - Flush wins if both requests arrive in the same cycle.
- **SW_WR:**
  - tbl_wr_en stays high; tbl_wr_addr and tbl_wr_data stay stable until accepted.
  - On acceptance → IDLE, with sw_wr_ack=1 for one cycle.
  - A table_flush seen here sets flush_pending; the beat is never aborted.
- **DRAIN:**
  - lookup_hold=1 and flush_busy=1.
  - On lookup_idle=1 → FLUSH, with tbl_wr_en=1, addr=0, data=0.
- **FLUSH:**
  - Each accepted beat increments the address.
  - Acceptance at addr TABLE_DEPTH-1 → DONE; tbl_wr_en=0.
- **DONE:**
  - flush_count += 1.
  - Next state is IDLE (or DRAIN if flush_pending is set). lookup_hold and flush_busy drop on entry to IDLE.
- **Queued flushes:**
  - table_flush seen in DRAIN, FLUSH or DONE sets flush_pending. At most one flush is queued; further requests merge into it.
  - A table_flush pulse in DRAIN/FLUSH/DONE therefore produces exactly one extra full flush.
- **Deferred software writes:**
  - sw_wr_req arriving during a flush is held off (no ack) and served in IDLE after the flush, unless another flush is pending.
- **Address counter:** TABLE_ADDR_WIDTH bits, reset to 0 on DRAIN→FLUSH. If TABLE_DEPTH < 2^TABLE_ADDR_WIDTH, addresses ≥ TABLE_DEPTH are never written.

## Timing
- **Reset:** state=IDLE, flush_pending=0. All outputs are 0 (sw_wr_ack, tbl_wr_en, tbl_wr_addr, tbl_wr_data, lookup_hold, flush_busy, flush_count).
- **Mid-operation reset:**
  - Aborts any flush or software beat in the next cycle.
  - The table is left partially written. No ack is issued for the aborted software write; the requester re-requests.
- **All outputs are registered.**
- **Software write latency** (tbl_wr_rdy=1):
  - req seen at t → tbl_wr_en at t+1 → sw_wr_ack at t+2.
  - Next write can start at t+3, since req is ignored while ack is high.
- **Flush latency** (tbl_wr_rdy=1, lookup_idle=1), table_flush at t:
  - lookup_hold and flush_busy at t+1.
  - First write beat at t+2.
  - Last beat at t+TABLE_DEPTH+1.
  - DONE at t+TABLE_DEPTH+2.
  - Hold drops and flush_count increments at t+TABLE_DEPTH+3.
- **tbl_wr_rdy low** stalls the current beat in place with no skipped addresses.

## Test plan
- Software write, rdy=1: addr=5, data=0xDEAD_BEEF → one beat at addr 5, ack 2 cycles after req, table_flush idle, flush_count=0.
- Flush, DEPTH=32, lookup_idle=1, rdy=1: 32 zero beats at addr 0..31 in consecutive cycles; hold high 34 cycles; flush_count=1.
- Flush with lookup_idle held low 10 cycles, rdy toggling 50%: no beat until idle; each addr written exactly once; no gaps or duplicates.
- Simultaneous table_flush and sw_wr_req (addr 3, data 0x1) in IDLE: flush completes first, then addr 3 ← 0x1; ack after DONE; final entry 3 = 0x1.
- table_flush pulsed twice during one flush → exactly two flushes total, flush_count=2.
- Reset asserted at flush beat addr 10 → next cycle all outputs 0, state IDLE; a subsequent flush restarts at addr 0.
